fft_addr_gen: RTL and testbench

In-place radix-2 DIT FFT address generator and sequencer. It drives the FFT-side port of `RAM_TOP`: `fft_busy`, `fft_rd_address1/2`, `fft_wr_address1/2` and `fft_wr_en`. In parallel it drives the twiddle ROM index and read-valid strobe to the butterfly datapath. Sample data never passes through this block; it only schedules butterflies and accounts for datapath latency.

---
 rtl/fft_addr_gen.sv | 221 ++++++++++++++++++++++
 tb/tb_fft_addr_gen.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/fft_addr_gen.sv
// fft_addr_gen: in-place radix-2 DIT FFT address generator and sequencer.
//
// It schedules one butterfly per cycle, stage by stage. Sample data never
// passes through this block. The read addresses and twiddle index go out on
// the read side. The same addresses come back on the write side exactly LAT
// cycles later, which is the latency of the butterfly datapath. A DRAIN
// period of LAT cycles closes every stage, so all writes of stage s commit
// before the first read of stage s+1.
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous, active-high reset (clears FSM, delay line, outputs)
//   start            one-cycle request for a full transform (ignored unless idle)
//   fft_busy         high while the transform runs (RUN and DRAIN)
//   fft_rd_address1  upper-leg read address
//   fft_rd_address2  lower-leg read address (upper + span)
//   rd_valid         read addresses are a real butterfly this cycle
//   tw_index         twiddle ROM index for the current read
//   stage            current stage, 0 .. address_width-1
//   fft_wr_address1  write-back address, upper leg (read address delayed by LAT)
//   fft_wr_address2  write-back address, lower leg
//   fft_wr_en        write strobe (rd_valid delayed by LAT)
//   done             one-cycle pulse when the transform is complete
module fft_addr_gen #(
  parameter int N             = 32,
  parameter int address_width = $clog2(N),
  parameter int LAT           = 3
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  output logic                               fft_busy,
  output logic [address_width-1:0]           fft_rd_address1,
  output logic [address_width-1:0]           fft_rd_address2,
  output logic                               rd_valid,
  output logic [address_width-2:0]           tw_index,
  output logic [$clog2(address_width)-1:0]   stage,
  output logic [address_width-1:0]           fft_wr_address1,
  output logic [address_width-1:0]           fft_wr_address2,
  output logic                               fft_wr_en,
  output logic                               done
);

  localparam int S  = address_width;        // number of stages
  localparam int BW = S - 1;                // butterfly index width (N/2 butterflies)
  localparam int SW = $clog2(S);            // stage counter width
  localparam int CW = $clog2(LAT + 1);      // drain counter width

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [BW-1:0] B_LAST        = BW'(N / 2 - 1);
  localparam logic [BW-1:0] B_ONE         = BW'(1);
  localparam logic [SW-1:0] STAGE_LAST    = SW'(S - 1);
  localparam logic [SW-1:0] STAGE_ONE     = SW'(1);
  localparam logic [CW-1:0] DRAIN_LAST    = CW'(LAT - 1);
  localparam logic [CW-1:0] CNT_ONE       = CW'(1);
  localparam logic [S-1:0]  ADDR_ONE      = S'(1);

  // Sequencer state
  logic [1:0]    state_r, state_nxt_s;
  logic [SW-1:0] stage_r, stage_nxt_s;
  logic [BW-1:0] b_r, b_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;

  // Address arithmetic for the butterfly that will be on the ports next cycle
  logic [S-1:0]  b_ext_s, span_s, mask_s, pos_s, rd1_s, rd2_s;
  logic [BW-1:0] tw_s;

  // Registered read-side outputs
  logic          busy_r, done_r, rd_valid_r;
  logic [S-1:0]  rd1_r, rd2_r;
  logic [BW-1:0] tw_r;
  logic [SW-1:0] stage_out_r;

  // Write-back delay line; entry LAT-1 drives the write port directly
  logic          dly_v_r  [LAT];
  logic [S-1:0]  dly_a1_r [LAT];
  logic [S-1:0]  dly_a2_r [LAT];

  // Next-state logic for the IDLE/RUN/DRAIN/DONE sequencer
  always_comb begin
    state_nxt_s = state_r;
    stage_nxt_s = stage_r;
    b_nxt_s     = b_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_nxt_s = ST_RUN;
          stage_nxt_s = '0;
          b_nxt_s     = '0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (b_r == B_LAST) begin
          state_nxt_s = ST_DRAIN;
          cnt_nxt_s   = '0;
        end else begin
          b_nxt_s = b_r + B_ONE;
        end
      end
      ST_DRAIN: begin
        if (cnt_r == DRAIN_LAST) begin
          if (stage_r == STAGE_LAST) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_RUN;
            stage_nxt_s = stage_r + STAGE_ONE;
            b_nxt_s     = '0;
          end
        end else begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
        stage_nxt_s = '0;
        b_nxt_s     = '0;
      end
      default: begin
        state_nxt_s = ST_IDLE;
        stage_nxt_s = '0;
        b_nxt_s     = '0;
        cnt_nxt_s   = '0;
      end
    endcase
  end

  // Butterfly addresses: insert a zero bit at position 'stage' of b for the
  // upper leg. The lower leg sets that bit. The twiddle index is pos scaled
  // up to the N/2-entry ROM.
  always_comb begin
    b_ext_s = {1'b0, b_nxt_s};
    span_s  = ADDR_ONE << stage_nxt_s;
    mask_s  = span_s - ADDR_ONE;
    pos_s   = b_ext_s & mask_s;
    rd1_s   = ((b_ext_s & ~mask_s) << 1'b1) | pos_s;
    rd2_s   = rd1_s | span_s;
    tw_s    = pos_s[BW-1:0] << (STAGE_LAST - stage_nxt_s);
  end

  // Sequencer state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      stage_r <= '0;
      b_r     <= '0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_nxt_s;
      stage_r <= stage_nxt_s;
      b_r     <= b_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Read-side output registers, loaded from next-state so they line up with the state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      rd_valid_r  <= 1'b0;
      rd1_r       <= '0;
      rd2_r       <= '0;
      tw_r        <= '0;
      stage_out_r <= '0;
    end else begin
      busy_r      <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_DRAIN);
      done_r      <= (state_nxt_s == ST_DONE);
      stage_out_r <= stage_nxt_s;
      if (state_nxt_s == ST_RUN) begin
        rd_valid_r <= 1'b1;
        rd1_r      <= rd1_s;
        rd2_r      <= rd2_s;
        tw_r       <= tw_s;
      end else begin
        rd_valid_r <= 1'b0;
        rd1_r      <= '0;
        rd2_r      <= '0;
        tw_r       <= '0;
      end
    end
  end

  // LAT-deep delay line turning each read into its in-place write-back
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) begin
        dly_v_r[i]  <= 1'b0;
        dly_a1_r[i] <= '0;
        dly_a2_r[i] <= '0;
      end
    end else begin
      dly_v_r[0]  <= rd_valid_r;
      dly_a1_r[0] <= rd1_r;
      dly_a2_r[0] <= rd2_r;
      for (int i = 1; i < LAT; i++) begin
        dly_v_r[i]  <= dly_v_r[i-1];
        dly_a1_r[i] <= dly_a1_r[i-1];
        dly_a2_r[i] <= dly_a2_r[i-1];
      end
    end
  end

  assign fft_busy        = busy_r;
  assign done            = done_r;
  assign rd_valid        = rd_valid_r;
  assign fft_rd_address1 = rd1_r;
  assign fft_rd_address2 = rd2_r;
  assign tw_index        = tw_r;
  assign stage           = stage_out_r;
  assign fft_wr_en       = dly_v_r[LAT-1];
  assign fft_wr_address1 = dly_a1_r[LAT-1];
  assign fft_wr_address2 = dly_a2_r[LAT-1];

endmodule

// File: tb/tb_fft_addr_gen.sv
// tb_fft_addr_gen: self-checking bench for fft_addr_gen (N=32, LAT=3).
// A cycle-indexed reference model gives the expected outputs. It counts
// the cycles since an accepted start and derives the addresses from the
// butterfly formulas with plain integer arithmetic. Randomised idle gaps,
// random start activity and a random reset point run alongside the directed
// scenarios.
module tb_fft_addr_gen;

  localparam int N    = 32;
  localparam int LAT  = 3;
  localparam int AW   = $clog2(N);
  localparam int SW   = $clog2(AW);
  localparam int S    = AW;
  localparam int HALF = N / 2;
  localparam int PER  = HALF + LAT;   // cycles per stage
  localparam int T    = S * PER;      // busy cycles per transform

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          fft_busy;
  logic [AW-1:0] fft_rd_address1, fft_rd_address2;
  logic          rd_valid;
  logic [AW-2:0] tw_index;
  logic [SW-1:0] stage;
  logic [AW-1:0] fft_wr_address1, fft_wr_address2;
  logic          fft_wr_en;
  logic          done;

  fft_addr_gen #(.N(N), .LAT(LAT)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .fft_busy        (fft_busy),
    .fft_rd_address1 (fft_rd_address1),
    .fft_rd_address2 (fft_rd_address2),
    .rd_valid        (rd_valid),
    .tw_index        (tw_index),
    .stage           (stage),
    .fft_wr_address1 (fft_wr_address1),
    .fft_wr_address2 (fft_wr_address2),
    .fft_wr_en       (fft_wr_en),
    .done            (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int run_c    = 0;      // model: cycle within current run (0 = idle), T+1 = done cycle
  int strobes  = 0;
  int wr_cnt [S][N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (run cycle %0d)", tag, obs, exp, run_c);
    end
  endtask

  // Expected read for run cycle c straight from the butterfly definitions
  function automatic void exp_read(input int c, output bit v, output int a1, output int a2,
                                   output int tw, output int st);
    int b, span;
    v = 1'b0; a1 = 0; a2 = 0; tw = 0; st = 0;
    if (c >= 1 && c <= T) begin
      st   = (c - 1) / PER;
      b    = (c - 1) % PER;
      v    = (b < HALF);
      span = 1 << st;
      a1   = (b / span) * 2 * span + (b % span);
      a2   = a1 + span;
      tw   = (b % span) << (S - 1 - st);
    end
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, fft_busy, 0);
    check({tag, "_rd1"}, fft_rd_address1, 0);
    check({tag, "_rd2"}, fft_rd_address2, 0);
    check({tag, "_rdv"}, rd_valid, 0);
    check({tag, "_tw"}, tw_index, 0);
    check({tag, "_stage"}, stage, 0);
    check({tag, "_wr1"}, fft_wr_address1, 0);
    check({tag, "_wr2"}, fft_wr_address2, 0);
    check({tag, "_wren"}, fft_wr_en, 0);
    check({tag, "_done"}, done, 0);
  endtask

  task automatic check_outputs();
    bit v, wv;
    int a1, a2, tw, st, w1, w2, wtw, wst, bad;
    exp_read(run_c, v, a1, a2, tw, st);
    exp_read(run_c - LAT, wv, w1, w2, wtw, wst);
    if (run_c == 1) begin
      strobes = 0;
      foreach (wr_cnt[i, j]) wr_cnt[i][j] = 0;
    end
    check("busy", fft_busy, 32'(run_c >= 1 && run_c <= T));
    check("done", done, 32'(run_c == T + 1));
    check("rd_valid", rd_valid, 32'(v));
    if (v) begin
      check("rd_addr1", fft_rd_address1, a1);
      check("rd_addr2", fft_rd_address2, a2);
      check("tw_index", tw_index, tw);
    end
    if (run_c >= 1 && run_c <= T) check("stage", stage, st);
    check("wr_en", fft_wr_en, 32'(wv));
    if (wv) begin
      check("wr_addr1", fft_wr_address1, w1);
      check("wr_addr2", fft_wr_address2, w2);
    end
    if (fft_wr_en === 1'b1 && run_c >= 1) begin
      strobes++;
      if (wv) begin
        wr_cnt[wst][fft_wr_address1]++;
        wr_cnt[wst][fft_wr_address2]++;
      end
    end
    // Hand-derived checkpoints for N=32, LAT=3
    case (run_c)
      1:  begin check("c1_rd1", fft_rd_address1, 0);  check("c1_rd2", fft_rd_address2, 1);  check("c1_tw", tw_index, 0); end
      2:  begin check("c2_rd1", fft_rd_address1, 2);  check("c2_rd2", fft_rd_address2, 3);  end
      4:  begin check("c4_wren", fft_wr_en, 1); check("c4_wr1", fft_wr_address1, 0); check("c4_wr2", fft_wr_address2, 1); end
      16: begin check("c16_rd1", fft_rd_address1, 30); check("c16_rd2", fft_rd_address2, 31); end
      20: begin check("c20_rd1", fft_rd_address1, 0);  check("c20_rd2", fft_rd_address2, 2);  check("c20_tw", tw_index, 0); end
      21: begin check("c21_rd1", fft_rd_address1, 1);  check("c21_rd2", fft_rd_address2, 3);  check("c21_tw", tw_index, 8); end
      22: begin check("c22_rd1", fft_rd_address1, 4);  check("c22_rd2", fft_rd_address2, 6);  check("c22_tw", tw_index, 0); end
      77: begin check("c77_rd1", fft_rd_address1, 0);  check("c77_rd2", fft_rd_address2, 16); check("c77_tw", tw_index, 0); end
      78: begin check("c78_rd1", fft_rd_address1, 1);  check("c78_rd2", fft_rd_address2, 17); check("c78_tw", tw_index, 1); end
      92: begin check("c92_rd1", fft_rd_address1, 15); check("c92_rd2", fft_rd_address2, 31); check("c92_tw", tw_index, 15); end
      95: begin check("c95_wren", fft_wr_en, 1); check("c95_busy", fft_busy, 1); end
      96: begin check("c96_done", done, 1); check("c96_busy", fft_busy, 0); end
      default: ;
    endcase
    if (run_c == T + 1) begin
      bad = 0;
      foreach (wr_cnt[i, j]) if (wr_cnt[i][j] != 1) bad++;
      check("wr_strobes", strobes, S * HALF);
      check("addr_coverage_errors", bad, 0);
    end
  endtask

  // One clock: drive start, advance model at the edge, check mid-cycle
  task automatic step(input bit st);
    start = st;
    @(posedge clk);
    if (reset) run_c = 0;
    else if (run_c == 0) run_c = start ? 1 : 0;
    else if (run_c <= T) run_c++;
    else run_c = 0;
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    int guard;
    int rst_at;
    reset = 1'b1;
    start = 1'b0;
    @(negedge clk);

    // Reset with clock running
    repeat (3) step(1'b0);
    check_zero("reset");

    // Start on the cycle after release; one full transform
    reset = 1'b0;
    step(1'b1);
    repeat (T + 5) step(1'b0);

    // Random idle gap, then random start activity during and after a run
    repeat ($urandom_range(1, 5)) step(1'b0);
    step(1'b1);
    repeat (T + 8) step(1'($urandom_range(0, 1)));
    repeat (T + 3) step(1'b0);

    // Start held high: one transform, the next accepted only from idle
    repeat (2 * T + 10) step(1'b1);
    repeat (T + 3) step(1'b0);

    // Reset in stage 2 (cycle 40)
    step(1'b1);
    guard = 0;
    while (run_c < 40 && guard < 200) begin
      step(1'b0);
      guard++;
    end
    check("reached_cycle_40", run_c, 40);
    reset = 1'b1;
    #1;
    check_zero("reset_mid");
    run_c = 0;
    repeat (2) step(1'b0);
    reset = 1'b0;
    repeat (LAT + 5) step(1'b0);
    step(1'b1);
    repeat (T + 3) step(1'b0);

    // Reset at a random point, then a fresh run
    rst_at = $urandom_range(2, T);
    step(1'b1);
    guard = 0;
    while (run_c < rst_at && guard < 200) begin
      step(1'b0);
      guard++;
    end
    reset = 1'b1;
    #1;
    check_zero("reset_rand");
    run_c = 0;
    step(1'b0);
    reset = 1'b0;
    repeat (LAT + 3) step(1'b0);
    step(1'b1);
    repeat (T + 3) step(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
